// File: rtl/sub_16_bit_serial_if.sv
// Handshake bundle for the nibble-serial 16-bit subtractor.
// Port V is present only when SUB16_OVERFLOW_EN is defined.
interface sub_16_bit_serial_if;
  logic [15:0] X;
  logic [15:0] Y;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] Z;
  logic        Borrow;
  logic        out_valid;
  logic        out_ready;
`ifdef SUB16_OVERFLOW_EN
  logic        V;
`endif

  modport master (
    output X, Y, in_valid, out_ready,
`ifdef SUB16_OVERFLOW_EN
    input  V,
`endif
    input  in_ready, Z, Borrow, out_valid
  );

  modport slave (
    input  X, Y, in_valid, out_ready,
`ifdef SUB16_OVERFLOW_EN
    output V,
`endif
    output in_ready, Z, Borrow, out_valid
  );
endinterface

// File: rtl/sub_16_bit_serial.sv
// Multi-cycle 16-bit unsigned subtractor, one nibble per clock, LSB nibble first.
// Optional signed-overflow output V is enabled by defining SUB16_OVERFLOW_EN.
module sub_16_bit_serial (
  input  logic           clk,
  input  logic           rst,
  sub_16_bit_serial_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      r_state;
  logic [1:0]  r_cnt;
  logic [15:0] r_x;
  logic [15:0] r_y;
  logic [15:0] r_z;
  logic        r_b;
  logic        r_borrow;
`ifdef SUB16_OVERFLOW_EN
  logic        r_v;
`endif

  logic [3:0]  w_x_nib;
  logic [3:0]  w_y_nib;
  logic [4:0]  w_diff;
  logic [15:0] w_z_next;

  // Bit 4 of the 5-bit result is the nibble borrow-out.
  function automatic logic [4:0] nib_sub(input logic [3:0] a, input logic [3:0] b, input logic bi);
    nib_sub = {1'b0, a} - {1'b0, b} - {4'b0000, bi};
  endfunction

  // Select the active nibble, subtract it, and merge the digit into the running Z.
  always_comb begin
    w_x_nib  = 4'h0;
    w_y_nib  = 4'h0;
    case (r_cnt)
      2'd0:    begin w_x_nib = r_x[3:0];   w_y_nib = r_y[3:0];   end
      2'd1:    begin w_x_nib = r_x[7:4];   w_y_nib = r_y[7:4];   end
      2'd2:    begin w_x_nib = r_x[11:8];  w_y_nib = r_y[11:8];  end
      2'd3:    begin w_x_nib = r_x[15:12]; w_y_nib = r_y[15:12]; end
      default: begin w_x_nib = 4'h0;       w_y_nib = 4'h0;       end
    endcase
    w_diff   = nib_sub(w_x_nib, w_y_nib, r_b);
    w_z_next = r_z;
    case (r_cnt)
      2'd0:    w_z_next[3:0]   = w_diff[3:0];
      2'd1:    w_z_next[7:4]   = w_diff[3:0];
      2'd2:    w_z_next[11:8]  = w_diff[3:0];
      2'd3:    w_z_next[15:12] = w_diff[3:0];
      default: w_z_next        = r_z;
    endcase
  end

  // Control FSM plus operand, result and borrow registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_cnt    <= 2'd0;
      r_x      <= 16'h0000;
      r_y      <= 16'h0000;
      r_z      <= 16'h0000;
      r_b      <= 1'b0;
      r_borrow <= 1'b0;
`ifdef SUB16_OVERFLOW_EN
      r_v      <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.in_valid) begin
            r_x     <= bus.X;
            r_y     <= bus.Y;
            r_z     <= 16'h0000;
            r_b     <= 1'b0;
            r_cnt   <= 2'd0;
            r_state <= S_CALC;
          end
        end
        S_CALC: begin
          r_z <= w_z_next;
          r_b <= w_diff[4];
          if (r_cnt == 2'd3) begin
            r_borrow <= w_diff[4];
`ifdef SUB16_OVERFLOW_EN
            r_v      <= (r_x[15] != r_y[15]) & (w_z_next[15] != r_x[15]);
`endif
            r_state  <= S_DONE;
          end else begin
            r_cnt <= r_cnt + 2'd1;
          end
        end
        S_DONE: begin
          if (bus.out_ready) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (r_state == S_IDLE);
  assign bus.out_valid = (r_state == S_DONE);
  assign bus.Z         = r_z;
  assign bus.Borrow    = r_borrow;
`ifdef SUB16_OVERFLOW_EN
  assign bus.V         = r_v;
`endif

endmodule

// File: tb/tb_sub_16_bit_serial.sv
// Self-checking bench for sub_16_bit_serial: transaction-level reference model
// compared every cycle, plus directed vectors with literal expectations.
module tb_sub_16_bit_serial;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sub_16_bit_serial_if bus();

  sub_16_bit_serial dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: tracks handshake phase and expected result from plain arithmetic.
  logic        m_started   = 1'b0;
  logic        m_in_ready  = 1'b1;
  logic        m_out_valid = 1'b0;
  logic        m_fresh     = 1'b0;
  int          m_pend      = 0;
  logic [15:0] m_z         = 16'h0000;
  logic        m_b         = 1'b0;
  logic        m_v         = 1'b0;

  function automatic logic ref_ovf(input logic [15:0] x, input logic [15:0] y);
    int sx;
    int sy;
    int d;
    sx = int'($signed(x));
    sy = int'($signed(y));
    d  = sx - sy;
    return (d > 32767) || (d < -32768);
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_started   <= 1'b1;
      m_in_ready  <= 1'b1;
      m_out_valid <= 1'b0;
      m_fresh     <= 1'b1;
      m_pend      <= 0;
    end else if (m_in_ready && bus.in_valid) begin
      m_in_ready <= 1'b0;
      m_fresh    <= 1'b0;
      m_pend     <= 4;
      m_z        <= 16'((32'(bus.X) + 32'h10000 - 32'(bus.Y)) % 32'h10000);
      m_b        <= (bus.X < bus.Y);
      m_v        <= ref_ovf(bus.X, bus.Y);
    end else if (m_pend > 0) begin
      m_pend <= m_pend - 1;
      if (m_pend == 1) m_out_valid <= 1'b1;
    end else if (m_out_valid && bus.out_ready) begin
      m_out_valid <= 1'b0;
      m_in_ready  <= 1'b1;
    end
  end

  always @(negedge clk) begin
    if (m_started) begin
      chk("in_ready", 16'(bus.in_ready), 16'(m_in_ready));
      chk("out_valid", 16'(bus.out_valid), 16'(m_out_valid));
      if (m_out_valid || m_fresh) begin
        chk("model_Z", bus.Z, m_fresh ? 16'h0000 : m_z);
        chk("model_Borrow", 16'(bus.Borrow), m_fresh ? 16'h0000 : 16'(m_b));
`ifdef SUB16_OVERFLOW_EN
        chk("model_V", 16'(bus.V), m_fresh ? 16'h0000 : 16'(m_v));
`endif
      end
    end
  end

  task automatic wait_ready();
    int n;
    n = 0;
    while (!bus.in_ready && n < 30) begin
      @(negedge clk);
      n++;
    end
    if (!bus.in_ready) begin
      tests++;
      fails++;
      $display("FAIL wait_ready: in_ready never rose");
    end
  endtask

  // Called at a negedge with in_valid already driven and in_ready high.
  task automatic wait_result(input string name, input logic [15:0] ez, input logic eb, input logic ev);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      bus.in_valid = 1'b0;
      n++;
    end while (!bus.out_valid && n < 20);
    chk({name, "_latency"}, 16'(n), 16'd5);
    chk({name, "_Z"}, bus.Z, ez);
    chk({name, "_Borrow"}, 16'(bus.Borrow), 16'(eb));
`ifdef SUB16_OVERFLOW_EN
    chk({name, "_V"}, 16'(bus.V), 16'(ev));
`else
    if (ev) begin end
`endif
  endtask

  task automatic op(input string name, input logic [15:0] x, input logic [15:0] y,
                    input logic [15:0] ez, input logic eb, input logic ev);
    wait_ready();
    bus.X        = x;
    bus.Y        = y;
    bus.in_valid = 1'b1;
    wait_result(name, ez, eb, ev);
  endtask

  task automatic consume();
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
  endtask

  initial begin
    int acc;
    int res;
    int t0;
    int t1;
    logic [15:0] z0;
    logic [15:0] z1;
    logic prev_ir;

    bus.X = 16'h0000;
    bus.Y = 16'h0000;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_Z", bus.Z, 16'h0000);
    chk("reset_Borrow", 16'(bus.Borrow), 16'h0000);
    chk("reset_out_valid", 16'(bus.out_valid), 16'h0000);
    chk("reset_in_ready", 16'(bus.in_ready), 16'h0001);
    rst = 1'b0;
    @(negedge clk);

    op("basic", 16'h1234, 16'h0234, 16'h1000, 1'b0, 1'b0);          consume();
    op("ripple", 16'h0000, 16'h0001, 16'hFFFF, 1'b1, 1'b0);         consume();
    op("equal", 16'hABCD, 16'hABCD, 16'h0000, 1'b0, 1'b0);          consume();
    op("ovf", 16'h8000, 16'h0001, 16'h7FFF, 1'b0, 1'b1);            consume();
    op("small", 16'h0005, 16'h0003, 16'h0002, 1'b0, 1'b0);          consume();
    op("negovf", 16'h7FFF, 16'hFFFF, 16'h8000, 1'b1, 1'b1);         consume();

    // Backpressure with competing operands presented while busy.
    op("bp", 16'h5555, 16'h1111, 16'h4444, 1'b0, 1'b0);
    bus.X = 16'h0F00;
    bus.Y = 16'h0100;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_hold_Z", bus.Z, 16'h4444);
      chk("bp_hold_in_ready", 16'(bus.in_ready), 16'h0000);
      chk("bp_hold_out_valid", 16'(bus.out_valid), 16'h0001);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    chk("bp_release_in_ready", 16'(bus.in_ready), 16'h0001);
    chk("bp_release_out_valid", 16'(bus.out_valid), 16'h0000);
    wait_result("bp_next", 16'h0E00, 1'b0, 1'b0);
    consume();

    // Reset on the second CALC cycle.
    wait_ready();
    bus.X = 16'h0F0F;
    bus.Y = 16'h0101;
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_Z", bus.Z, 16'h0000);
    chk("midrst_Borrow", 16'(bus.Borrow), 16'h0000);
    chk("midrst_out_valid", 16'(bus.out_valid), 16'h0000);
    chk("midrst_in_ready", 16'(bus.in_ready), 16'h0001);
    op("after_rst", 16'h0010, 16'h0001, 16'h000F, 1'b0, 1'b0);     consume();

    // Back-to-back with out_ready held high.
    wait_ready();
    acc = 0;
    res = 0;
    t0  = 0;
    t1  = 0;
    z0  = 16'h0000;
    z1  = 16'h0000;
    bus.X = 16'h1000;
    bus.Y = 16'h0001;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    prev_ir = bus.in_ready;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (prev_ir && bus.in_valid) begin
        acc++;
        if (acc == 1) begin
          bus.X = 16'h0001;
          bus.Y = 16'h0002;
        end else begin
          bus.in_valid = 1'b0;
        end
      end
      if (bus.out_valid && res < 2) begin
        if (res == 0) begin t0 = c; z0 = bus.Z; end
        else          begin t1 = c; z1 = bus.Z; end
        res++;
      end
      prev_ir = bus.in_ready;
    end
    bus.out_ready = 1'b0;
    chk("b2b_count", 16'(res), 16'd2);
    chk("b2b_Z0", z0, 16'h0FFF);
    chk("b2b_Z1", z1, 16'hFFFF);
    chk("b2b_spacing", 16'(t1 - t0), 16'd6);

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
